// File: rtl/pixel_clock_gen.sv
// pixel_clock_gen
// Multi-channel pixel-clock generator running on the fast PLL output clock.
// The raw PLL lock is qualified by requiring LOCK_WAIT consecutive high
// samples. Each channel then divides in_clk by a runtime-programmable ratio.
// It produces a one-cycle enable strobe per period and a registered square wave.
//
// Ports:
//   in_clk      fast clock; all logic runs on its rising edge
//   reset       synchronous, active-high reset
//   pll_lock    raw PLL lock, synchronous to in_clk
//   div_sel     target channel of a divisor update
//   div_value   requested divisor (0 and 1 are clamped to 2)
//   div_valid   update request
//   div_ready   high when no update is outstanding
//   locked      qualified lock
//   clk_en      per-channel one-cycle strobe, once per divisor period
//   clk_out     per-channel registered divided clock
//   div_active  per-channel divisor in use, channel i at [i*DIV_W +: DIV_W]
module pixel_clock_gen #(
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 10,
    parameter int LOCK_WAIT   = 1024,
    parameter int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      in_clk,
    input  logic                      reset,
    input  logic                      pll_lock,
    input  logic [SEL_W-1:0]          div_sel,
    input  logic [DIV_W-1:0]          div_value,
    input  logic                      div_valid,
    output logic                      div_ready,
    output logic                      locked,
    output logic [CHANNELS-1:0]       clk_en,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS*DIV_W-1:0] div_active
);

    localparam int LCNT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LOCK_WAIT - 1);

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_state_t;

    lock_state_t       lock_state;
    logic [LCNT_W-1:0] lcnt;
    logic              lock_next;

    logic              pending;
    logic [SEL_W-1:0]  pend_sel;
    logic [DIV_W-1:0]  pend_val;

    logic [DIV_W-1:0]  ccnt      [CHANNELS];
    logic [DIV_W-1:0]  div_cur   [CHANNELS];
    logic [DIV_W-1:0]  ccnt_next [CHANNELS];
    logic [DIV_W-1:0]  d_next    [CHANNELS];
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] apply_now;
    logic [CHANNELS-1:0] clk_out_next;
    logic [DIV_W:0]    half;

    assign locked    = (lock_state == LOCKED);
    assign div_ready = !pending;
    assign clk_en    = wrap;

    // The lock state that will hold after this edge. The channel counters and
    // clk_out use it, so they clear on the same edge that locked falls.
    always_comb begin
        lock_next = 1'b0;
        if (lock_state == LOCKED) begin
            lock_next = pll_lock;
        end else begin
            lock_next = pll_lock && (lcnt == LCNT_LAST);
        end
    end

    // Lock qualifier. Any low sample restarts the consecutive-high count.
    always_ff @(posedge in_clk) begin
        if (reset) begin
            lock_state <= UNLOCKED;
            lcnt       <= '0;
        end else begin
            case (lock_state)
                UNLOCKED: begin
                    if (!pll_lock) begin
                        lcnt <= '0;
                    end else if (lcnt == LCNT_LAST) begin
                        lock_state <= LOCKED;
                    end else begin
                        lcnt <= lcnt + LCNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (!pll_lock) begin
                        lock_state <= UNLOCKED;
                        lcnt       <= '0;
                    end
                end
                default: begin
                    lock_state <= UNLOCKED;
                    lcnt       <= '0;
                end
            endcase
        end
    end

    // Per-channel next state. A pending update lands at the target channel's
    // wrap, so the wrapping period keeps the old divisor. When unlocked there is
    // no period to finish, and the update lands on the next edge.
    // clk_out is decoded from the next counter and divisor so that the flop
    // output lines up with ccnt.
    always_comb begin
        half = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wrap[i]         = locked && (ccnt[i] == div_cur[i] - DIV_W'(1));
            apply_now[i]    = pending && (32'(pend_sel) == i) && (!locked || wrap[i]);
            d_next[i]       = apply_now[i] ? pend_val : div_cur[i];
            ccnt_next[i]    = '0;
            if (locked && lock_next && !wrap[i]) begin
                ccnt_next[i] = ccnt[i] + DIV_W'(1);
            end
            half            = ({1'b0, d_next[i]} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
            clk_out_next[i] = lock_next && ({1'b0, ccnt_next[i]} < half);
        end
    end

    // Channel registers
    always_ff @(posedge in_clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (reset) begin
                ccnt[i]    <= '0;
                div_cur[i] <= DIV_W'(DEFAULT_DIV);
                clk_out[i] <= 1'b0;
            end else begin
                ccnt[i]    <= ccnt_next[i];
                div_cur[i] <= d_next[i];
                clk_out[i] <= clk_out_next[i];
            end
        end
    end

    // Update handshake. Only one update can be outstanding at a time.
    // A request for a channel that does not exist is accepted and dropped.
    always_ff @(posedge in_clk) begin
        if (reset) begin
            pending  <= 1'b0;
            pend_sel <= '0;
            pend_val <= '0;
        end else if (pending) begin
            if (|apply_now) begin
                pending <= 1'b0;
            end
        end else if (div_valid) begin
            if (32'(div_sel) < CHANNELS) begin
                pending  <= 1'b1;
                pend_sel <= div_sel;
                pend_val <= (div_value < DIV_W'(2)) ? DIV_W'(2) : div_value;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_active
        assign div_active[g*DIV_W +: DIV_W] = div_cur[g];
    end

endmodule

// File: tb/tb_pixel_clock_gen.sv
// tb_pixel_clock_gen
// Self-checking bench for pixel_clock_gen with two channels, 8-bit divisors,
// a default divisor of 10 and a lock wait of 16 cycles. A 2-bit select is used
// so that out-of-range channels can be requested.
// Ports: none (top-level bench).
module tb_pixel_clock_gen;

    localparam int CH    = 2;
    localparam int DW    = 8;
    localparam int DDIV  = 10;
    localparam int LWAIT = 16;

    logic          in_clk = 1'b0;
    logic          reset = 1'b0;
    logic          pll_lock = 1'b0;
    logic [1:0]    div_sel = '0;
    logic [DW-1:0] div_value = '0;
    logic          div_valid = 1'b0;
    logic          div_ready;
    logic          locked;
    logic [CH-1:0] clk_en;
    logic [CH-1:0] clk_out;
    logic [CH*DW-1:0] div_active;

    int checks = 0;
    int passes = 0;

    // Reference model state, kept in terms of lock run length and per-channel phase
    int run_high;
    bit m_locked;
    int phase [CH];
    int dm [CH];
    bit m_pend;
    int m_psel;
    int m_pval;

    typedef struct {
        bit         rst;
        bit         pl;
        bit         dv;
        logic [1:0] sel;
        logic [7:0] val;
        int         cycles;
        bit         exp_locked;
        bit         exp_ready;
        logic [1:0] exp_en;
        logic [1:0] exp_out;
        logic [7:0] exp_act0;
        logic [7:0] exp_act1;
    } vec_t;

    vec_t vecs[$];

    pixel_clock_gen #(
        .CHANNELS   (CH),
        .DIV_W      (DW),
        .DEFAULT_DIV(DDIV),
        .LOCK_WAIT  (LWAIT),
        .SEL_W      (2)
    ) dut (
        .in_clk    (in_clk),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .div_sel   (div_sel),
        .div_value (div_value),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .locked    (locked),
        .clk_en    (clk_en),
        .clk_out   (clk_out),
        .div_active(div_active)
    );

    always #5 in_clk = ~in_clk;

    // Watchdog so the run always terminates
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_value(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h required %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance the model by one rising edge with the given inputs
    task automatic model_edge(input bit rst, input bit pl, input bit dv,
                              input logic [1:0] sel, input logic [7:0] val);
        bit prev_locked;
        int d_old [CH];
        if (rst) begin
            run_high = 0;
            m_locked = 1'b0;
            m_pend   = 1'b0;
            m_psel   = 0;
            m_pval   = 0;
            for (int c = 0; c < CH; c++) begin
                phase[c] = 0;
                dm[c]    = DDIV;
            end
        end else begin
            prev_locked = m_locked;
            for (int c = 0; c < CH; c++) d_old[c] = dm[c];
            run_high = pl ? run_high + 1 : 0;
            m_locked = prev_locked ? pl : (run_high >= LWAIT);
            if (m_pend) begin
                if (!prev_locked || phase[m_psel] == d_old[m_psel] - 1) begin
                    dm[m_psel] = m_pval;
                    m_pend     = 1'b0;
                end
            end else if (dv && int'(sel) < CH) begin
                m_pend = 1'b1;
                m_psel = int'(sel);
                m_pval = (val < 2) ? 2 : int'(val);
            end
            for (int c = 0; c < CH; c++) begin
                if (prev_locked && m_locked) phase[c] = (phase[c] + 1) % d_old[c];
                else phase[c] = 0;
            end
        end
    endtask

    // Compare every DUT output against the model
    task automatic checkOutput();
        logic [1:0] e_en;
        logic [1:0] e_out;
        for (int c = 0; c < CH; c++) begin
            e_en[c]  = m_locked && (phase[c] == dm[c] - 1);
            e_out[c] = m_locked && (2 * phase[c] < dm[c]);
        end
        check_value("model_locked", 32'(locked), 32'(m_locked));
        check_value("model_clk_en", 32'(clk_en), 32'(e_en));
        check_value("model_clk_out", 32'(clk_out), 32'(e_out));
        check_value("model_div_ready", 32'(div_ready), 32'(!m_pend));
        check_value("model_div_active0", 32'(div_active[7:0]), 32'(dm[0]));
        check_value("model_div_active1", 32'(div_active[15:8]), 32'(dm[1]));
    endtask

    // Drive inputs at the falling edge, clock once, then check at the next falling edge
    task automatic applyStimulus(input bit rst, input bit pl, input bit dv,
                                 input logic [1:0] sel, input logic [7:0] val);
        reset     = rst;
        pll_lock  = pl;
        div_valid = dv;
        div_sel   = sel;
        div_value = val;
        @(posedge in_clk);
        model_edge(rst, pl, dv, sel, val);
        @(negedge in_clk);
        checkOutput();
    endtask

    task automatic idle(input int n, input bit pl);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, pl, 1'b0, 2'd0, 8'd0);
    endtask

    // Idle with lock held until a selected strobe appears, within a cycle budget
    task automatic wait_for_en(input logic [1:0] mask, input int budget, input string name);
        int n;
        n = 0;
        while ((clk_en & mask) == 2'b00 && n < budget) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
            n++;
        end
        check_value({name, "_strobe_seen"}, 32'((clk_en & mask) != 2'b00), 32'd1);
    endtask

    function automatic vec_t mk(input bit rst, input bit pl, input bit dv, input logic [1:0] sel,
                                input logic [7:0] val, input int cycles, input bit el, input bit er,
                                input logic [1:0] een, input logic [1:0] eout,
                                input logic [7:0] ea0, input logic [7:0] ea1);
        vec_t v;
        v.rst = rst; v.pl = pl; v.dv = dv; v.sel = sel; v.val = val; v.cycles = cycles;
        v.exp_locked = el; v.exp_ready = er; v.exp_en = een; v.exp_out = eout;
        v.exp_act0 = ea0; v.exp_act1 = ea1;
        return v;
    endfunction

    initial begin
        bit r;
        bit p;
        bit v;
        // Reset, qualified lock and the default period of 10
        vecs.push_back(mk(1, 0, 0, 0, 0,  2, 0, 1, 2'b00, 2'b00, 10, 10));
        vecs.push_back(mk(0, 1, 0, 0, 0, 15, 0, 1, 2'b00, 2'b00, 10, 10));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 1, 1, 2'b00, 2'b11, 10, 10));
        vecs.push_back(mk(0, 1, 0, 0, 0,  9, 1, 1, 2'b11, 2'b00, 10, 10));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 1, 1, 2'b00, 2'b11, 10, 10));
        vecs.push_back(mk(0, 1, 0, 0, 0,  5, 1, 1, 2'b00, 2'b00, 10, 10));
        // Lock loss, then a one-cycle glitch after 10 highs
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 1, 2'b00, 2'b00, 10, 10));
        vecs.push_back(mk(0, 1, 0, 0, 0, 10, 0, 1, 2'b00, 2'b00, 10, 10));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 1, 2'b00, 2'b00, 10, 10));
        vecs.push_back(mk(0, 1, 0, 0, 0, 15, 0, 1, 2'b00, 2'b00, 10, 10));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 1, 1, 2'b00, 2'b11, 10, 10));
        // Runtime change of channel 0 to 7, issued mid-period
        vecs.push_back(mk(0, 1, 1, 0, 7,  1, 1, 0, 2'b00, 2'b11, 10, 10));
        vecs.push_back(mk(0, 1, 0, 0, 0,  7, 1, 0, 2'b00, 2'b00, 10, 10));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 1, 0, 2'b11, 2'b00, 10, 10));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 1, 1, 2'b00, 2'b11,  7, 10));
        vecs.push_back(mk(0, 1, 0, 0, 0,  6, 1, 1, 2'b01, 2'b00,  7, 10));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 1, 1, 2'b00, 2'b01,  7, 10));

        @(negedge in_clk);
        for (int i = 0; i < vecs.size(); i++) begin
            for (int c = 0; c < vecs[i].cycles; c++) begin
                applyStimulus(vecs[i].rst, vecs[i].pl, vecs[i].dv, vecs[i].sel, vecs[i].val);
            end
            check_value($sformatf("vec%0d_locked", i), 32'(locked), 32'(vecs[i].exp_locked));
            check_value($sformatf("vec%0d_ready", i), 32'(div_ready), 32'(vecs[i].exp_ready));
            check_value($sformatf("vec%0d_clk_en", i), 32'(clk_en), 32'(vecs[i].exp_en));
            check_value($sformatf("vec%0d_clk_out", i), 32'(clk_out), 32'(vecs[i].exp_out));
            check_value($sformatf("vec%0d_act0", i), 32'(div_active[7:0]), 32'(vecs[i].exp_act0));
            check_value($sformatf("vec%0d_act1", i), 32'(div_active[15:8]), 32'(vecs[i].exp_act1));
        end

        // Clamp: a divisor of 1 on channel 1 becomes 2, giving 1 high / 1 low
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 8'd1);
        check_value("clamp_ready_low", 32'(div_ready), 32'd0);
        wait_for_en(2'b10, 20, "clamp_apply");
        idle(1, 1'b1);
        check_value("clamp_active1", 32'(div_active[15:8]), 32'd2);
        wait_for_en(2'b10, 4, "clamp_period");
        check_value("clamp_out_low", 32'(clk_out[1]), 32'd0);
        idle(1, 1'b1);
        check_value("clamp_en_gap", 32'(clk_en[1]), 32'd0);
        check_value("clamp_out_high", 32'(clk_out[1]), 32'd1);
        idle(1, 1'b1);
        check_value("clamp_en_again", 32'(clk_en[1]), 32'd1);

        // Discard: channel 2 does not exist
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 8'd5);
        check_value("discard_ready", 32'(div_ready), 32'd1);
        check_value("discard_act0", 32'(div_active[7:0]), 32'd7);
        check_value("discard_act1", 32'(div_active[15:8]), 32'd2);

        // Lock loss while a channel 0 update is pending
        wait_for_en(2'b01, 20, "loss_sync");
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 8'd4);
        check_value("loss_pending", 32'(div_ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        check_value("loss_locked", 32'(locked), 32'd0);
        check_value("loss_clk_en", 32'(clk_en), 32'd0);
        check_value("loss_clk_out", 32'(clk_out), 32'd0);
        check_value("loss_act0_old", 32'(div_active[7:0]), 32'd7);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        check_value("loss_act0_new", 32'(div_active[7:0]), 32'd4);
        check_value("loss_ready", 32'(div_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 8'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        check_value("relock_act1", 32'(div_active[15:8]), 32'd4);
        idle(LWAIT, 1'b1);
        check_value("relock_locked", 32'(locked), 32'd1);
        wait_for_en(2'b11, 10, "relock_first");
        check_value("relock_in_phase", 32'(clk_en), 32'b11);

        // Reset mid-operation drops the pending update
        wait_for_en(2'b01, 10, "reset_sync");
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 8'd9);
        check_value("reset_pending", 32'(div_ready), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
        check_value("reset_locked", 32'(locked), 32'd0);
        check_value("reset_clk_en", 32'(clk_en), 32'd0);
        check_value("reset_clk_out", 32'(clk_out), 32'd0);
        check_value("reset_ready", 32'(div_ready), 32'd1);
        check_value("reset_active", 32'(div_active), 32'h0a0a);
        idle(LWAIT + 30, 1'b1);
        check_value("reset_dropped", 32'(div_active[7:0]), 32'd10);

        // Randomised traffic against the model
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(399) == 0);
            p = ($urandom_range(49) != 0);
            v = ($urandom_range(3) == 0);
            applyStimulus(r, p, v, 2'($urandom_range(3)), 8'($urandom_range(15)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
